// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational-read program ROM between the fetch
// stage and the execute stage. One access is granted per cycle. The read data
// is registered back to the winner one cycle later. Data reads normally win a
// conflict. A wait counter forces a fetch grant after MAX_WAIT consecutive losses.
//
// Optional feature macro: ROM_ARB_PERF_EN adds a saturating 16-bit
// conflict_cnt output that counts cycles with both requests high.
module rom_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_valid,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [DATA_W-1:0] rom_read_value
`ifdef ROM_ARB_PERF_EN
   ,
   output logic [15:0]       conflict_cnt
`endif
);

   typedef enum logic [0:0] {
      ST_NORMAL  = 1'b0,
      ST_FORCE_F = 1'b1
   } state_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
   localparam logic [3:0] WAIT_SAT_C = 4'd15;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_wait_cnt;
   logic [3:0]        w_wait_inc;
   logic [3:0]        w_wait_nxt;
   logic              w_f_gnt;
   logic              w_d_gnt;
   logic              w_f_loses;
   logic [ADDR_W-1:0] w_rom_address;
   logic [DATA_W-1:0] r_f_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_f_valid;
   logic              r_d_valid;

   // Grant decision: priority depends on FSM state, and nothing is granted while reset is asserted
   always_comb begin
      w_f_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (!rst_n) begin
         w_f_gnt = 1'b0;
         w_d_gnt = 1'b0;
      end else begin
         case (r_state)
            ST_FORCE_F: begin
               if (f_req) begin
                  w_f_gnt = 1'b1;
               end else if (d_req) begin
                  w_d_gnt = 1'b1;
               end else begin
                  w_f_gnt = 1'b0;
                  w_d_gnt = 1'b0;
               end
            end
            ST_NORMAL: begin
               if (d_req) begin
                  w_d_gnt = 1'b1;
               end else if (f_req) begin
                  w_f_gnt = 1'b1;
               end else begin
                  w_f_gnt = 1'b0;
                  w_d_gnt = 1'b0;
               end
            end
            default: begin
               w_f_gnt = 1'b0;
               w_d_gnt = 1'b0;
            end
         endcase
      end
   end

   // ROM address mux: the winner's address, or zero when idle or in reset
   always_comb begin
      w_rom_address = '0;
      if (w_f_gnt) begin
         w_rom_address = f_addr;
      end else if (w_d_gnt) begin
         w_rom_address = d_addr;
      end else begin
         w_rom_address = '0;
      end
   end

   // Starvation counter next value: count consecutive fetch losses, saturating at 15
   always_comb begin
      w_f_loses  = f_req & ~w_f_gnt;
      w_wait_inc = r_wait_cnt;
      w_wait_nxt = 4'd0;
      if (r_wait_cnt == WAIT_SAT_C) begin
         w_wait_inc = WAIT_SAT_C;
      end else begin
         w_wait_inc = r_wait_cnt + 4'd1;
      end
      if (w_f_loses) begin
         w_wait_nxt = w_wait_inc;
      end else begin
         w_wait_nxt = 4'd0;
      end
   end

   // FSM next state: force fetch after MAX_WAIT losses, release after a fetch grant or a dropped fetch request
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_NORMAL: begin
            if (w_f_loses && (w_wait_inc == MAX_WAIT_C)) begin
               w_state_nxt = ST_FORCE_F;
            end else begin
               w_state_nxt = ST_NORMAL;
            end
         end
         ST_FORCE_F: begin
            if (w_f_gnt || !f_req) begin
               w_state_nxt = ST_NORMAL;
            end else begin
               w_state_nxt = ST_FORCE_F;
            end
         end
         default: begin
            w_state_nxt = ST_NORMAL;
         end
      endcase
   end

   // State, starvation counter, and read-data/valid registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_NORMAL;
         r_wait_cnt <= 4'd0;
         r_f_rdata  <= '0;
         r_d_rdata  <= '0;
         r_f_valid  <= 1'b0;
         r_d_valid  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_f_valid  <= w_f_gnt;
         r_d_valid  <= w_d_gnt;
         if (w_f_gnt) begin
            r_f_rdata <= rom_read_value;
         end
         if (w_d_gnt) begin
            r_d_rdata <= rom_read_value;
         end
      end
   end

`ifdef ROM_ARB_PERF_EN
   logic [15:0] r_conflict_cnt;

   // Conflict counter: count cycles with both requests high, saturating at all-ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_conflict_cnt <= 16'd0;
      end else if (f_req && d_req && (r_conflict_cnt != 16'hFFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign conflict_cnt = r_conflict_cnt;
`endif

   assign f_gnt       = w_f_gnt;
   assign d_gnt       = w_d_gnt;
   assign rom_address = w_rom_address;
   assign f_rdata     = r_f_rdata;
   assign d_rdata     = r_d_rdata;
   assign f_valid     = r_f_valid;
   assign d_valid     = r_d_valid;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench for rom_arbiter (MAX_WAIT = 3). The ROM is
// modelled as ROM[n] = n + 16'h1000. Inputs change on the falling edge.
// Grants and rom_address are checked before the rising edge. Registered
// outputs are checked 1 ns after the rising edge.
module tb_rom_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   logic              clk;
   logic              rst_n;
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic [DATA_W-1:0] f_rdata;
   logic              f_valid;
   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_gnt;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_read_value;
`ifdef ROM_ARB_PERF_EN
   logic [15:0]       conflict_cnt;
`endif

   int n_checks;
   int n_errors;

   rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(3)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .f_req          (f_req),
      .f_addr         (f_addr),
      .f_gnt          (f_gnt),
      .f_rdata        (f_rdata),
      .f_valid        (f_valid),
      .d_req          (d_req),
      .d_addr         (d_addr),
      .d_gnt          (d_gnt),
      .d_rdata        (d_rdata),
      .d_valid        (d_valid),
      .rom_address    (rom_address),
      .rom_read_value (rom_read_value)
`ifdef ROM_ARB_PERF_EN
      ,
      .conflict_cnt   (conflict_cnt)
`endif
   );

   // ROM model: combinational read, ROM[n] = n + 16'h1000
   assign rom_read_value = rom_address + 16'h1000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One arbitration cycle: drive requests, check grants/address, then check registered results
   task automatic step(input string tag,
                       input logic fr, input logic [15:0] fa,
                       input logic dr, input logic [15:0] da,
                       input logic exp_fg, input logic exp_dg);
      logic [15:0] exp_addr;
      @(negedge clk);
      f_req  = fr;
      f_addr = fa;
      d_req  = dr;
      d_addr = da;
      #1;
      exp_addr = exp_fg ? fa : (exp_dg ? da : 16'h0000);
      check_val({tag, ".f_gnt"}, {31'd0, f_gnt}, {31'd0, exp_fg});
      check_val({tag, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, exp_dg});
      check_val({tag, ".rom_address"}, {16'd0, rom_address}, {16'd0, exp_addr});
      @(posedge clk);
      #1;
      check_val({tag, ".f_valid"}, {31'd0, f_valid}, {31'd0, exp_fg});
      check_val({tag, ".d_valid"}, {31'd0, d_valid}, {31'd0, exp_dg});
      if (exp_fg) begin
         check_val({tag, ".f_rdata"}, {16'd0, f_rdata}, {16'd0, fa + 16'h1000});
      end
      if (exp_dg) begin
         check_val({tag, ".d_rdata"}, {16'd0, d_rdata}, {16'd0, da + 16'h1000});
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n  = 1'b0;
      f_req  = 1'b0;
      f_addr = 16'h0000;
      d_req  = 1'b0;
      d_addr = 16'h0000;

      // Reset held for two edges, no requests
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("rst.f_valid", {31'd0, f_valid}, 32'd0);
      check_val("rst.d_valid", {31'd0, d_valid}, 32'd0);
      check_val("rst.f_rdata", {16'd0, f_rdata}, 32'd0);
      check_val("rst.d_rdata", {16'd0, d_rdata}, 32'd0);
      check_val("rst.f_gnt", {31'd0, f_gnt}, 32'd0);
      check_val("rst.d_gnt", {31'd0, d_gnt}, 32'd0);
      check_val("rst.rom_address", {16'd0, rom_address}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step("idle", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Lone fetch, back-to-back grants
      for (int i = 0; i < 3; i++) begin
         step("lone_f", 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b0);
      end
      step("idle2", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Conflict: data wins 3 times, fetch is forced, then data wins again
      for (int i = 0; i < 3; i++) begin
         step("conf_d", 1'b1, 16'h0020, 1'b1, 16'h0030, 1'b0, 1'b1);
      end
      step("conf_force", 1'b1, 16'h0020, 1'b1, 16'h0030, 1'b1, 1'b0);
      step("conf_after", 1'b0, 16'h0020, 1'b1, 16'h0030, 1'b0, 1'b1);
      check_val("loser_hold.f_rdata", {16'd0, f_rdata}, 32'h0000_1020);
      step("idle3", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Fetch drop: 2 losses, drop one cycle, then 3 fresh losses before a forced grant
      for (int i = 0; i < 2; i++) begin
         step("drop_pre", 1'b1, 16'h0040, 1'b1, 16'h0050, 1'b0, 1'b1);
      end
      step("drop_gap", 1'b0, 16'h0040, 1'b1, 16'h0050, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step("drop_post", 1'b1, 16'h0040, 1'b1, 16'h0050, 1'b0, 1'b1);
      end
      step("drop_force", 1'b1, 16'h0040, 1'b1, 16'h0050, 1'b1, 1'b0);
      step("idle4", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // In forced state with fetch withdrawn: lone data is granted and priority returns to data
      for (int i = 0; i < 3; i++) begin
         step("ff_pre", 1'b1, 16'h0070, 1'b1, 16'h0060, 1'b0, 1'b1);
      end
      step("ff_lone_d", 1'b0, 16'h0070, 1'b1, 16'h0061, 1'b0, 1'b1);
      step("ff_back", 1'b1, 16'h0070, 1'b1, 16'h0062, 1'b0, 1'b1);
      step("idle5", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Reset during a data request: no grant, no valid, registers cleared
      @(negedge clk);
      d_req  = 1'b1;
      d_addr = 16'h0080;
      rst_n  = 1'b0;
      #1;
      check_val("rstmid.d_gnt", {31'd0, d_gnt}, 32'd0);
      check_val("rstmid.rom_address", {16'd0, rom_address}, 32'd0);
      @(posedge clk);
      #1;
      check_val("rstmid.d_valid", {31'd0, d_valid}, 32'd0);
      check_val("rstmid.d_rdata", {16'd0, d_rdata}, 32'd0);
      check_val("rstmid.f_rdata", {16'd0, f_rdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d_req = 1'b0;

      // Post-reset: wait counter starts from zero
      for (int i = 0; i < 3; i++) begin
         step("post_rst", 1'b1, 16'h0090, 1'b1, 16'h00A0, 1'b0, 1'b1);
      end
      step("post_force", 1'b1, 16'h0090, 1'b1, 16'h00A0, 1'b1, 1'b0);
      step("idle6", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

`ifdef ROM_ARB_PERF_EN
      // Conflict counter: 10 more conflict cycles after the 4 above
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         f_req = 1'b1;
         d_req = 1'b1;
      end
      @(negedge clk);
      f_req = 1'b0;
      d_req = 1'b0;
      check_val("perf.conflict_cnt", {16'd0, conflict_cnt}, 32'd14);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
